// File: rtl/stopwatch_ctrl_if.sv
// Button levels in, counter-control pulses and status out, for the stopwatch sequencer.
// master: button panel / bench side; slave: stopwatch_ctrl.
interface stopwatch_ctrl_if;
   logic       btn_run;
   logic       btn_lap;
   logic       inc;
   logic       ctr_clear;
   logic       freeze;
   logic       running;
   logic [1:0] state;

   modport master (
      output btn_run,
      output btn_lap,
      input  inc,
      input  ctr_clear,
      input  freeze,
      input  running,
      input  state
   );

   modport slave (
      input  btn_run,
      input  btn_lap,
      output inc,
      output ctr_clear,
      output freeze,
      output running,
      output state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear sequencer and tick prescaler for the cascaded digit counters.
// Latency: one cycle from button rise to new state; inc/ctr_clear are same-cycle combinational.
// Backpressure: none; button edges are acted on immediately and never queued.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 100000,
   parameter int DIV_WID  = 17
) (
   input  logic          clk,
   input  logic          reset,
   stopwatch_ctrl_if.slave sw
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      STOPPED = 2'd2,
      LAP     = 2'd3
   } state_t;

   localparam logic [DIV_WID-1:0] TICK_MAX = DIV_WID'(TICK_DIV - 1);

   state_t             state_q;
   state_t             state_nxt;
   logic [DIV_WID-1:0] div_cnt;
   logic [DIV_WID-1:0] div_nxt;
   logic               run_q;
   logic               lap_q;
   logic               run_e;
   logic               lap_e;
   logic               tick;
   logic               is_running;
   logic               clear;

   // Button history loads even under reset so a held button cannot look like a fresh press.
   always_ff @(posedge clk) begin
      run_q <= sw.btn_run;
      lap_q <= sw.btn_lap;
      if (reset) begin
         state_q <= IDLE;
         div_cnt <= '0;
      end else begin
         state_q <= state_nxt;
         div_cnt <= div_nxt;
      end
   end

   always_comb begin
      run_e      = sw.btn_run & ~run_q;
      lap_e      = sw.btn_lap & ~lap_q;
      is_running = (state_q == RUNNING) || (state_q == LAP);
      tick       = (div_cnt == TICK_MAX);
      state_nxt  = state_q;
      div_nxt    = div_cnt;
      clear      = 1'b0;

      // run_e wins outright; a simultaneous lap_e is dropped, including its clear.
      case (state_q)
         IDLE: begin
            div_nxt = '0;
            if (run_e)
               state_nxt = RUNNING;
            else if (lap_e)
               clear = 1'b1;
         end
         RUNNING, LAP: begin
            div_nxt = tick ? '0 : div_cnt + DIV_WID'(1);
            if (run_e)
               state_nxt = STOPPED;
            else if (lap_e)
               state_nxt = (state_q == RUNNING) ? LAP : RUNNING;
         end
         STOPPED: begin
            if (run_e)
               state_nxt = RUNNING;
            else if (lap_e) begin
               state_nxt = IDLE;
               clear     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sw.inc       = is_running & tick;
   assign sw.ctr_clear = clear;
   assign sw.freeze    = (state_q == LAP);
   assign sw.running   = is_running;
   assign sw.state     = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed + randomized bench for stopwatch_ctrl at TICK_DIV=4, checked against a table-driven model.
module tb_stopwatch_ctrl;
   localparam int TD = 4;

   logic clk;
   logic reset;
   stopwatch_ctrl_if swif ();

   stopwatch_ctrl #(.TICK_DIV(TD), .DIV_WID(3)) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (swif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int inc_log[$];

   // Model: state number, running-cycle count since last clear, previous button levels.
   int   m_state = 0;
   int   m_acc   = 0;
   logic m_rq    = 1'b0;
   logic m_lq    = 1'b0;
   // Next state indexed by [state][event], event 0=none 1=run press 2=lap press.
   int   nxt_tbl [4][3] = '{'{0, 1, 0}, '{1, 2, 3}, '{2, 1, 0}, '{3, 2, 1}};

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic r, input logic l);
      logic re, le, run_m;
      int   ev;
      @(negedge clk);
      reset        = rst;
      swif.btn_run = r;
      swif.btn_lap = l;
      #1;
      re    = r & ~m_rq;
      le    = l & ~m_lq;
      ev    = re ? 1 : (le ? 2 : 0);
      run_m = (m_state == 1) || (m_state == 3);
      chk("state",   {2'b00, swif.state},     4'(m_state));
      chk("running", {3'b000, swif.running},  {3'b000, run_m});
      chk("freeze",  {3'b000, swif.freeze},   {3'b000, (m_state == 3)});
      chk("inc",     {3'b000, swif.inc},      {3'b000, run_m && (m_acc % TD == TD - 1)});
      chk("clear",   {3'b000, swif.ctr_clear},
          {3'b000, le && !re && (m_state == 0 || m_state == 2)});
      if (swif.inc === 1'b1) inc_log.push_back(cyc);
      @(posedge clk);
      m_rq = r;
      m_lq = l;
      if (rst) begin
         m_state = 0;
         m_acc   = 0;
      end else begin
         if (m_state == 0) m_acc = 0;
         else if (run_m)   m_acc = m_acc + 1;
         m_state = nxt_tbl[m_state][ev];
      end
      cyc++;
   endtask

   function automatic bit logged(input int c);
      foreach (inc_log[i]) if (inc_log[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      int resume_cyc;
      logic r, l;
      reset        = 1'b1;
      swif.btn_run = 1'b0;
      swif.btn_lap = 1'b0;

      // 1: reset, run press at cycle 10, inc at 14/18/22
      repeat (3) step(1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b0);
      chk("t1_inc_count", 4'(inc_log.size()), 4'd3);
      chk("t1_inc14", {3'b000, logged(14)}, 4'd1);
      chk("t1_inc18", {3'b000, logged(18)}, 4'd1);
      chk("t1_inc22", {3'b000, logged(22)}, 4'd1);

      // 2: stop at phase 2, resume 20 cycles later; inc on first running cycle
      for (int i = 0; i < 8 && (m_acc % TD) != 2; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      inc_log.delete();
      repeat (19) step(1'b0, 1'b0, 1'b0);
      chk("t2_no_inc_stopped", 4'(inc_log.size()), 4'd0);
      resume_cyc = cyc;
      step(1'b0, 1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0, 1'b0);
      chk("t2_inc_resume", {3'b000, logged(resume_cyc + 1)}, 4'd1);
      chk("t2_inc_next",   {3'b000, logged(resume_cyc + 5)}, 4'd1);

      // 3: lap in and out while running
      step(1'b0, 1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // 4: stop, clear from STOPPED, clear again from IDLE
      step(1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      // 5: simultaneous presses while running
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      chk("t5_state_stopped", {2'b00, swif.state}, 4'd2);

      // 6: run held through reset release; then reset mid-LAP
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b1, 1'b0);
      chk("t6_held_idle", {2'b00, swif.state}, 4'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("t6_lap_reset", {1'b0, swif.state, swif.freeze}, 4'd0);

      // Randomized button activity with occasional reset
      r = 1'b0;
      l = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) r = ~r;
         if ($urandom_range(0, 6) == 0) l = ~l;
         step(($urandom_range(0, 299) == 0), r, l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
